// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch generator / pulse monitor pair:
// measurement FSM states, report framing and flag bit positions.
package glitch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DELAY,
      ST_HIGH,
      ST_LOW,
      ST_REPORT
   } state_t;

   localparam logic [7:0] REPORT_HDR   = 8'hA5;
   localparam int         REPORT_LEN   = 9;
   localparam int         FLAG_TIMEOUT = 0;
   localparam int         FLAG_SAT     = 1;

endpackage

// File: rtl/report_serializer.sv
// Sends a report record one byte per accepted valid/ready transfer, header first.
// The record is captured in parallel on start so the measurement can move on.
module report_serializer
   import glitch_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [8*REPORT_LEN-1:0]   record,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      done
);

   localparam logic [3:0] LAST_IDX = 4'(REPORT_LEN - 1);

   logic [7:0] byte_p0 [REPORT_LEN];
   logic [3:0] idx;
   logic       vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REPORT_LEN; i++) byte_p0[i] <= '0;
         idx <= '0;
         vld <= 1'b0;
      end else if (abort) begin
         idx <= '0;
         vld <= 1'b0;
      end else if (start) begin
         for (int i = 0; i < REPORT_LEN; i++) byte_p0[i] <= record[8*(REPORT_LEN-1-i) +: 8];
         idx <= '0;
         vld <= 1'b1;
      end else if (vld && tx_ready) begin
         if (idx == LAST_IDX) begin
            idx <= '0;
            vld <= 1'b0;
         end else begin
            idx <= idx + 4'd1;
         end
      end
   end

   assign tx_data  = byte_p0[idx];
   assign tx_valid = vld;
   assign done     = vld & tx_ready & (idx == LAST_IDX) & ~abort;

endmodule

// File: rtl/pulse_monitor.sv
// Measures trigger->first-pulse delay, first width, first spacing and pulse count
// of a looped-back glitch train, then emits a 9-byte report on a byte stream.
module pulse_monitor
   import glitch_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 65535,
   parameter int GAP_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm_i,
   input  logic       abort_i,
   input  logic       trigger_i,
   input  logic       pulse_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   output logic       armed_o,
   output logic       busy_o
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP_CYCLES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Synchroniser stages: _p0/_p1 resynchronise, _p2 holds the previous sample
   logic trig_p0, trig_p1, trig_p2;
   logic pulse_p0, pulse_p1, pulse_p2;
   logic trig_rise, pulse_rise, pulse_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_p0  <= 1'b0;
         trig_p1  <= 1'b0;
         trig_p2  <= 1'b0;
         pulse_p0 <= 1'b0;
         pulse_p1 <= 1'b0;
         pulse_p2 <= 1'b0;
      end else begin
         trig_p0  <= trigger_i;
         trig_p1  <= trig_p0;
         trig_p2  <= trig_p1;
         pulse_p0 <= pulse_i;
         pulse_p1 <= pulse_p0;
         pulse_p2 <= pulse_p1;
      end
   end

   assign trig_rise  = trig_p1 & ~trig_p2;
   assign pulse_rise = pulse_p1 & ~pulse_p2;
   assign pulse_fall = ~pulse_p1 & pulse_p2;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, delay, delay_n, width, width_n, spacing, spacing_n;
   logic [7:0]       count, count_n;
   logic             sat, sat_n, tmo, tmo_n;
   logic             ser_start, ser_done;
   logic [7:0]       flags;
   logic [8*REPORT_LEN-1:0] record;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         delay   <= '0;
         width   <= '0;
         spacing <= '0;
         count   <= '0;
         sat     <= 1'b0;
         tmo     <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         delay   <= delay_n;
         width   <= width_n;
         spacing <= spacing_n;
         count   <= count_n;
         sat     <= sat_n;
         tmo     <= tmo_n;
      end
   end

   // cnt holds cycles elapsed since the last edge, so it is loaded with 1 on each
   // edge and a captured value equals the exact edge-to-edge distance.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      delay_n   = delay;
      width_n   = width;
      spacing_n = spacing;
      count_n   = count;
      sat_n     = sat;
      tmo_n     = tmo;
      ser_start = 1'b0;
      if (abort_i) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm_i) begin
                  state_n   = ST_ARMED;
                  cnt_n     = '0;
                  delay_n   = '0;
                  width_n   = '0;
                  spacing_n = '0;
                  count_n   = '0;
                  sat_n     = 1'b0;
                  tmo_n     = 1'b0;
               end
            end
            ST_ARMED: begin
               if (trig_rise) begin
                  cnt_n = CNT_ONE;
                  if (pulse_rise) begin
                     delay_n = '0;
                     count_n = 8'd1;
                     state_n = ST_HIGH;
                  end else begin
                     state_n = ST_DELAY;
                  end
               end
            end
            ST_DELAY: begin
               if (pulse_rise) begin
                  delay_n = cnt;
                  count_n = 8'd1;
                  cnt_n   = CNT_ONE;
                  state_n = ST_HIGH;
               end else if (cnt == TIMEOUT_C) begin
                  delay_n = cnt;
                  tmo_n   = 1'b1;
                  count_n = '0;
                  state_n = ST_REPORT;
               end else begin
                  sat_n = sat | (cnt == CNT_MAX);
                  cnt_n = sat_inc(cnt);
               end
            end
            ST_HIGH: begin
               if (pulse_fall) begin
                  if (count == 8'd1) width_n = cnt;
                  cnt_n   = CNT_ONE;
                  state_n = ST_LOW;
               end else begin
                  sat_n = sat | (cnt == CNT_MAX);
                  cnt_n = sat_inc(cnt);
               end
            end
            ST_LOW: begin
               if (pulse_rise) begin
                  if (count == 8'd1) spacing_n = cnt;
                  sat_n   = sat | (count == 8'hFF);
                  count_n = sat_inc8(count);
                  cnt_n   = CNT_ONE;
                  state_n = ST_HIGH;
               end else if (cnt == GAP_C) begin
                  state_n = ST_REPORT;
               end else begin
                  sat_n = sat | (cnt == CNT_MAX);
                  cnt_n = sat_inc(cnt);
               end
            end
            ST_REPORT: begin
               ser_start = ~tx_valid_o;
               if (ser_done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      flags               = '0;
      flags[FLAG_SAT]     = sat;
      flags[FLAG_TIMEOUT] = tmo;
      record = {REPORT_HDR, 16'(delay), 16'(width), 16'(spacing), count, flags};
   end

   report_serializer u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (ser_start),
      .abort    (abort_i),
      .record   (record),
      .tx_data  (tx_data_o),
      .tx_valid (tx_valid_o),
      .tx_ready (tx_ready_i),
      .done     (ser_done)
   );

   assign armed_o = (state == ST_ARMED);
   assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_pulse_monitor.sv
// Directed bench for pulse_monitor: input waveforms are recorded and a
// trace-level model derives the expected report from the recorded edges.
module tb_pulse_monitor;
   import glitch_pkg::*;

   localparam int TIMEOUT = 200;
   localparam int GAP     = 64;
   localparam int MAXC    = 65535;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       arm_i = 1'b0, abort_i = 1'b0, trigger_i = 1'b0, pulse_i = 1'b0;
   logic       tx_ready_i = 1'b1;
   logic [7:0] tx_data_o;
   logic       tx_valid_o, armed_o, busy_o;

   always #5 clk = ~clk;

   pulse_monitor #(.CNT_W(16), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm_i      (arm_i),
      .abort_i    (abort_i),
      .trigger_i  (trigger_i),
      .pulse_i    (pulse_i),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .armed_o    (armed_o),
      .busy_o     (busy_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Recorded input trace of the current measurement, one sample per clock
   bit   tq[$];
   bit   pq[$];
   int   meas_id = 0;
   bit   rec_en = 1'b0;
   bit   expect_none = 1'b0;
   bit   rand_rdy = 1'b0;
   int   got = 0;

   function automatic bit is_rise(input int i);
      return pq[i] && (i == 0 || !pq[i-1]);
   endfunction

   function automatic logic [71:0] model_report();
      int n = tq.size();
      int t = -1, p = -1, r, f, nxt;
      int delay = 0, width = 0, spacing = 0, count = 0;
      bit sat = 1'b0, tmo = 1'b0;
      for (int i = 0; i < n; i++) if (t < 0 && tq[i] && (i == 0 || !tq[i-1])) t = i;
      if (t < 0) return '0;
      for (int i = t; i < n; i++) if (p < 0 && is_rise(i)) p = i;
      if (p < 0 || p - t > TIMEOUT) begin
         tmo = 1'b1;
         delay = TIMEOUT;
      end else begin
         delay = p - t;
         r = p;
         while (1) begin
            count++;
            f = -1;
            for (int i = r + 1; i < n && f < 0; i++) if (!pq[i]) f = i;
            if (f < 0) break;
            if (f - r > MAXC) sat = 1'b1;
            if (count == 1) width = (f - r > MAXC) ? MAXC : f - r;
            nxt = -1;
            for (int i = f + 1; i < n && nxt < 0; i++) if (pq[i]) nxt = i;
            if (nxt < 0 || nxt - f > GAP) break;
            if (count == 1) spacing = nxt - f;
            r = nxt;
         end
         if (count > 255) begin
            count = 255;
            sat = 1'b1;
         end
      end
      return {8'hA5, 16'(delay), 16'(width), 16'(spacing), 8'(count), 6'b0, sat, tmo};
   endfunction

   // Trace recording and per-cycle output checking, sampled mid-cycle
   int          seen_id = 0;
   logic [71:0] exp_rec = '0;
   logic        pv_valid = 1'b0, pv_ready = 1'b0;
   logic [7:0]  pv_data = '0;

   always @(negedge clk) begin
      if (seen_id != meas_id) begin
         seen_id = meas_id;
         tq.delete();
         pq.delete();
         got = 0;
      end
      if (rec_en) begin
         tq.push_back(trigger_i);
         pq.push_back(pulse_i);
      end
      if (!rst_n) begin
         pv_valid = 1'b0;
      end else begin
         if (pv_valid && !pv_ready) begin
            check("hold_valid", 72'(tx_valid_o), 72'(1));
            check("hold_data", 72'(tx_data_o), 72'(pv_data));
         end
         if (tx_valid_o && tx_ready_i) begin
            if (expect_none) begin
               check("no_report_valid", 72'(tx_valid_o), 72'(0));
            end else begin
               if (got == 0) exp_rec = model_report();
               if (got < REPORT_LEN)
                  check($sformatf("byte%0d", got), 72'(tx_data_o), 72'(exp_rec[8*(REPORT_LEN-1-got) +: 8]));
               else
                  check("extra_byte", 72'(tx_valid_o), 72'(0));
               got++;
            end
         end
         pv_valid = tx_valid_o;
         pv_ready = tx_ready_i;
         pv_data  = tx_data_o;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rand_rdy) tx_ready_i = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic begin_meas();
      meas_id++;
      rec_en = 1'b1;
      tick(1);
      arm_i = 1'b1;
      tick(1);
      arm_i = 1'b0;
      check("armed", 72'(armed_o), 72'(1));
      tick(3);
   endtask

   task automatic train(input int d, input int n, input int w, input int s);
      trigger_i = 1'b1;
      if (d > 0) tick(d);
      for (int k = 0; k < n; k++) begin
         pulse_i = 1'b1;
         tick(w);
         pulse_i = 1'b0;
         if (k < n - 1) tick(s);
      end
   endtask

   task automatic finish_meas(input string name, input int budget);
      int c = 0;
      while (busy_o && c < budget) begin
         tick(1);
         c++;
      end
      check({name, "_idle"}, 72'(busy_o), 72'(0));
      tick(1);
      check({name, "_nbytes"}, 72'(got), 72'(REPORT_LEN));
   endtask

   task automatic end_meas();
      rec_en = 1'b0;
      trigger_i = 1'b0;
      tick(4);
   endtask

   initial begin
      int c;
      tick(3);
      check("rst_valid", 72'(tx_valid_o), 72'(0));
      check("rst_data", 72'(tx_data_o), 72'(0));
      check("rst_armed", 72'(armed_o), 72'(0));
      check("rst_busy", 72'(busy_o), 72'(0));
      rst_n = 1'b1;
      tick(2);

      // single pulse, delay 100, width 10
      begin_meas();
      train(100, 1, 10, 0);
      finish_meas("t1", GAP + 40);
      check("t1_model", model_report(), 72'hA5_0064_000A_0000_01_00);
      end_meas();

      // three pulses, same-cycle trigger and pulse edges
      begin_meas();
      train(0, 3, 5, 20);
      finish_meas("t2", GAP + 40);
      check("t2_model", model_report(), 72'hA5_0000_0005_0014_03_00);
      end_meas();

      // trigger without pulses -> timeout report
      begin_meas();
      train(1, 0, 0, 0);
      tick(100);
      check("t3_busy_mid", 72'(busy_o), 72'(1));
      finish_meas("t3", TIMEOUT + 40);
      check("t3_model", model_report(), 72'hA5_00C8_0000_0000_00_01);
      end_meas();

      // random back-pressure during the report
      rand_rdy = 1'b1;
      begin_meas();
      train(7, 2, 3, 4);
      finish_meas("t4", GAP + 200);
      check("t4_model", model_report(), 72'hA5_0007_0003_0004_02_00);
      rand_rdy = 1'b0;
      tx_ready_i = 1'b1;
      end_meas();

      // abort while the first pulse is high
      begin_meas();
      trigger_i = 1'b1;
      tick(5);
      pulse_i = 1'b1;
      tick(3);
      expect_none = 1'b1;
      abort_i = 1'b1;
      tick(1);
      abort_i = 1'b0;
      check("t5_abort_busy", 72'(busy_o), 72'(0));
      check("t5_abort_armed", 72'(armed_o), 72'(0));
      tick(4);
      pulse_i = 1'b0;
      tick(GAP + 20);
      check("t5_abort_valid", 72'(tx_valid_o), 72'(0));
      check("t5_abort_busy2", 72'(busy_o), 72'(0));
      end_meas();
      expect_none = 1'b0;

      // reset while the report is stalled
      tx_ready_i = 1'b0;
      begin_meas();
      train(4, 1, 6, 0);
      c = 0;
      while (!tx_valid_o && c < GAP + 20) begin
         tick(1);
         c++;
      end
      check("t5_report_valid", 72'(tx_valid_o), 72'(1));
      rst_n = 1'b0;
      trigger_i = 1'b0;
      #1;
      check("t5_rst_valid", 72'(tx_valid_o), 72'(0));
      check("t5_rst_data", 72'(tx_data_o), 72'(0));
      check("t5_rst_busy", 72'(busy_o), 72'(0));
      check("t5_rst_armed", 72'(armed_o), 72'(0));
      tick(2);
      rst_n = 1'b1;
      tx_ready_i = 1'b1;
      tick(2);
      check("t5_post_valid", 72'(tx_valid_o), 72'(0));
      check("t5_post_busy", 72'(busy_o), 72'(0));
      end_meas();

      // re-arm after reset
      begin_meas();
      train(12, 1, 2, 0);
      finish_meas("t5_rearm", GAP + 40);
      check("t5_rearm_model", model_report(), 72'hA5_000C_0002_0000_01_00);
      end_meas();

      // over-long pulse saturates the width counter
      begin_meas();
      train(5, 1, 70000, 0);
      finish_meas("t6", GAP + 40);
      check("t6_model", model_report(), 72'hA5_0005_FFFF_0000_01_02);
      end_meas();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
